// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a shared AES-128 core: captures the
// winner's key/plaintext, starts the core, times out a silent core, returns the response.
module aes_req_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    input  logic [127:0] pt0,
    input  logic [127:0] pt1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [127:0] core_key,
    output logic [127:0] core_pt,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_ct,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic [127:0] rsp_ct,
    input  logic         rsp_ready,
    output logic         busy
);

    localparam int unsigned DW = 128;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            last_id_q, last_id_d;
    logic            armed_q;
    logic [DW-1:0]   key_q, key_d;
    logic [DW-1:0]   pt_q, pt_d;
    logic            rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_ct_q, rsp_ct_d;
    logic            core_start_q;
    logic            rsp_valid_q;
    logic            busy_q;
    logic            win0_c;
    logic            gnt0_c, gnt1_c;

    // Requester 0 wins when alone or when requester 1 was served last.
    assign win0_c = req0 & (~req1 | last_id_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        last_id_d = last_id_q;
        key_d     = key_q;
        pt_d      = pt_q;
        rsp_id_d  = rsp_id_q;
        rsp_err_d = rsp_err_q;
        rsp_ct_d  = rsp_ct_q;
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        case (state_q)
            IDLE: begin
                // armed_q holds grants off until the first edge after reset release
                if (armed_q && (req0 || req1)) begin
                    gnt0_c   = win0_c;
                    gnt1_c   = ~win0_c;
                    rsp_id_d = ~win0_c;
                    key_d    = win0_c ? key0 : key1;
                    pt_d     = win0_c ? pt0 : pt1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    rsp_ct_d  = core_ct;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    rsp_ct_d  = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_id_d = rsp_id_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            last_id_q    <= 1'b1;
            armed_q      <= 1'b0;
            key_q        <= '0;
            pt_q         <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_ct_q     <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_id_q    <= last_id_d;
            armed_q      <= 1'b1;
            key_q        <= key_d;
            pt_q         <= pt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_ct_q     <= rsp_ct_d;
            core_start_q <= (state_d == ISSUE);
            rsp_valid_q  <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
        end
    end

    // Grant is a same-cycle acknowledge of the capture edge; everything else is a register.
    assign gnt0       = gnt0_c;
    assign gnt1       = gnt1_c;
    assign core_key   = key_q;
    assign core_pt    = pt_q;
    assign core_start = core_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_ct     = rsp_ct_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter: reset, single request, latency, timeout,
// backpressure, done/timeout collision, contention and reset during WAIT.
module tb_aes_req_arbiter;

    localparam int unsigned T = 15;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'hfedcba9876543210f0e1d2c3b4a59687;
    localparam logic [127:0] PT_B  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk;
    logic         rst_;
    logic         req0, req1;
    logic [127:0] key0, key1, pt0, pt1;
    logic         gnt0, gnt1;
    logic [127:0] core_key, core_pt;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_ct;
    logic         rsp_valid, rsp_id, rsp_err;
    logic [127:0] rsp_ct;
    logic         rsp_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    aes_req_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_(rst_),
        .req0(req0), .req1(req1),
        .key0(key0), .key1(key1), .pt0(pt0), .pt1(pt1),
        .gnt0(gnt0), .gnt1(gnt1),
        .core_key(core_key), .core_pt(core_pt), .core_start(core_start),
        .core_done(core_done), .core_ct(core_ct),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_ct(rsp_ct),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; req0 = 1'b1; req1 = 1'b1;
        key0 = KEY_A; pt0 = PT_A; key1 = KEY_B; pt1 = PT_B;
        core_done = 1'b0; core_ct = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL reset_gnt: got %b%b exp 00", gnt0, gnt1);
        end
        checks++;
        if (core_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: got start=%b valid=%b busy=%b exp 0", core_start, rsp_valid, busy);
        end
        checks++;
        if (rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_ct !== '0) begin
            failures++; $display("FAIL reset_rsp: got id=%b err=%b ct=%h exp 0", rsp_id, rsp_err, rsp_ct);
        end
        checks++;
        if (core_key !== '0 || core_pt !== '0) begin
            failures++; $display("FAIL reset_core: got key=%h pt=%h exp 0", core_key, core_pt);
        end
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL gnt_before_edge: got %b%b exp 00", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_single();
        int starts;
        key0 = KEY_A; pt0 = PT_A; req0 = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL single_gnt: got %b%b exp gnt0=1 gnt1=0", gnt0, gnt1);
        end
        step();
        req0 = 1'b0;
        checks++;
        if (core_key !== KEY_A || core_pt !== PT_A) begin
            failures++; $display("FAIL single_capture: got key=%h pt=%h exp %h %h", core_key, core_pt, KEY_A, PT_A);
        end
        checks++;
        if (core_start !== 1'b1 || gnt0 !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_issue: got start=%b gnt0=%b busy=%b exp 1 0 1", core_start, gnt0, busy);
        end
        starts = 0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (core_start === 1'b1) starts++;
        end
        core_done = 1'b1; core_ct = CT_A;
        step();
        core_done = 1'b0; core_ct = '0;
        checks++;
        if (starts !== 0) begin
            failures++; $display("FAIL single_one_start: got %0d extra starts exp 0", starts);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_ct !== CT_A) begin
            failures++; $display("FAIL single_rsp: got v=%b id=%b err=%b ct=%h exp 1 0 0 %h", rsp_valid, rsp_id, rsp_err, rsp_ct, CT_A);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_release: got v=%b busy=%b exp 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_latency();
        key1 = KEY_B; pt1 = PT_B; req1 = 1'b1;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            failures++; $display("FAIL lat_gnt: got %b%b exp gnt0=0 gnt1=1", gnt0, gnt1);
        end
        step();
        req1 = 1'b0;
        checks++;
        if (core_key !== KEY_B || core_pt !== PT_B || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL lat_issue: got key=%h pt=%h v=%b", core_key, core_pt, rsp_valid);
        end
        step();
        core_done = 1'b1; core_ct = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL lat_early: got v=%b exp 0", rsp_valid);
        end
        step();
        core_done = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_ct !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin
            failures++; $display("FAIL lat_rsp: got v=%b id=%b ct=%h exp 1 1", rsp_valid, rsp_id, rsp_ct);
        end
        step();
    endtask

    task automatic test_timeout();
        logic early;
        req0 = 1'b1; key0 = KEY_A; pt0 = PT_A;
        #1;
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL to_gnt: got %b exp 1", gnt0);
        end
        step();
        req0 = 1'b0;
        core_done = 1'b1; core_ct = 128'hdead;
        checks++;
        if (core_start !== 1'b1) begin
            failures++; $display("FAIL to_start: got %b exp 1", core_start);
        end
        early = 1'b0;
        for (int i = 1; i <= int'(T) + 2; i++) begin
            step();
            if (i == 1) core_done = 1'b0;
            if (i < int'(T) + 2 && rsp_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL to_early: got response before TIMEOUT+2 exp none");
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_ct !== '0 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL to_rsp: got v=%b err=%b id=%b ct=%h exp 1 1 0 0", rsp_valid, rsp_err, rsp_id, rsp_ct);
        end
        core_ct = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic bad;
        rsp_ready = 1'b0;
        req1 = 1'b1;
        #1;
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++; $display("FAIL bp_gnt: got %b exp 1", gnt1);
        end
        step();
        req1 = 1'b0; req0 = 1'b1;
        step();
        core_done = 1'b1; core_ct = 128'h0123456789abcdef0123456789abcdef;
        step();
        core_done = 1'b0; core_ct = '0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 ||
                rsp_ct !== 128'h0123456789abcdef0123456789abcdef ||
                gnt0 !== 1'b0 || gnt1 !== 1'b0 || core_start !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("FAIL bp_hold: got v=%b ct=%h gnt0=%b start=%b during hold", rsp_valid, rsp_ct, gnt0, core_start);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++; $display("FAIL bp_accept: got v=%b exp 1", rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || gnt0 !== 1'b1) begin
            failures++; $display("FAIL bp_after: got v=%b gnt0=%b exp 0 1", rsp_valid, gnt0);
        end
        req0 = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL bp_idle: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_collision();
        logic early;
        req1 = 1'b1;
        #1;
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++; $display("FAIL col_gnt: got %b exp 1", gnt1);
        end
        step();
        req1 = 1'b0;
        early = 1'b0;
        for (int i = 1; i <= int'(T) + 1; i++) begin
            step();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        core_done = 1'b1; core_ct = 128'hcafef00d_0000_1111_2222_333344445555;
        step();
        core_done = 1'b0; core_ct = '0;
        checks++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL col_early: got response before collision cycle exp none");
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_ct !== 128'hcafef00d_0000_1111_2222_333344445555) begin
            failures++; $display("FAIL col_rsp: got v=%b err=%b ct=%h exp 1 0", rsp_valid, rsp_err, rsp_ct);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_id;
        logic got;
        rst_ = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        key0 = KEY_A; key1 = KEY_B;
        step();
        rst_ = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_id = n[0];
            got = 1'b0;
            for (int w = 0; w < 6; w++) begin
                if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (got !== 1'b1 || gnt0 !== ~exp_id || gnt1 !== exp_id) begin
                failures++; $display("FAIL cont_gnt%0d: got gnt0=%b gnt1=%b exp id %b", n, gnt0, gnt1, exp_id);
            end
            step();
            checks++;
            if (core_key !== (exp_id ? KEY_B : KEY_A)) begin
                failures++; $display("FAIL cont_key%0d: got %h exp id %b key", n, core_key, exp_id);
            end
            step();
            core_done = 1'b1; core_ct = {4{32'(n)}};
            step();
            core_done = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_ct !== {4{32'(n)}}) begin
                failures++; $display("FAIL cont_rsp%0d: got v=%b id=%b ct=%h exp id %b", n, rsp_valid, rsp_id, rsp_ct, exp_id);
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic bad;
        req0 = 1'b1; key0 = KEY_A; pt0 = PT_A;
        #1;
        step();
        req0 = 1'b0;
        repeat (3) step();
        #2;
        rst_ = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || core_start !== 1'b0 || rsp_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++; $display("FAIL mid_ctrl: got busy=%b start=%b v=%b exp 0", busy, core_start, rsp_valid);
        end
        checks++;
        if (core_key !== '0 || core_pt !== '0 || rsp_ct !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL mid_data: got key=%h ct=%h id=%b exp 0", core_key, rsp_ct, rsp_id);
        end
        @(negedge clk);
        rst_ = 1'b1;
        step();
        core_done = 1'b1; core_ct = CT_A;
        step();
        core_done = 1'b0; core_ct = '0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("FAIL mid_late_done: got v=%b busy=%b exp no response", rsp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_timeout();
        test_backpressure();
        test_collision();
        test_contention();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion exp finish before 100us");
        $fatal(1);
    end

endmodule
